button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 101 ++++++++++
 tb/tb_button_conditioner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : Two independent pushbutton channels (start, user), each with a
//            2-flop synchronizer, debounced level and one-cycle press pulse.
//            Define BUTTON_CONDITIONER_DEBOUNCE_EN to compile in the debounce
//            counters; otherwise the level follows the synchronizer directly.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_start_raw,
    input  logic btn_user_raw,
    output logic start_trigger,
    output logic user_trigger,
    output logic start_level,
    output logic user_level
);

    localparam int c_NUM_CH = 2;

    logic [c_NUM_CH-1:0] w_raw;
    logic [c_NUM_CH-1:0] w_level;
    logic [c_NUM_CH-1:0] w_trig;

    assign w_raw = {btn_user_raw, btn_start_raw};

    // The counter is 16 bits wide, so the threshold must fit without wrapping.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce_cycles
        $error("button_conditioner: DEBOUNCE_CYCLES must lie within 1..65535");
    end

    for (genvar g = 0; g < c_NUM_CH; g++) begin : g_channel
        logic r_s1_q;
        logic r_s2_q;
        logic r_level_q;
        logic r_trig_q;
        logic w_s1_d;
        logic w_s2_d;
        logic w_level_d;
        logic w_trig_d;
`ifdef BUTTON_CONDITIONER_DEBOUNCE_EN
        localparam logic [15:0] c_CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
        logic [15:0] r_cnt_q;
        logic [15:0] w_cnt_d;
`endif

        always_comb begin
            w_s1_d = w_raw[g];
            w_s2_d = r_s1_q;
`ifdef BUTTON_CONDITIONER_DEBOUNCE_EN
            // Any sample matching the current level discards the partial count.
            w_cnt_d   = '0;
            w_level_d = r_level_q;
            if (r_s2_q != r_level_q) begin
                if (r_cnt_q == c_CNT_LAST) begin
                    w_level_d = r_s2_q;
                end else begin
                    w_cnt_d = r_cnt_q + 16'd1;
                end
            end
`else
            w_level_d = r_s2_q;
`endif
            w_trig_d = w_level_d & ~r_level_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1_q    <= 1'b0;
                r_s2_q    <= 1'b0;
                r_level_q <= 1'b0;
                r_trig_q  <= 1'b0;
`ifdef BUTTON_CONDITIONER_DEBOUNCE_EN
                r_cnt_q   <= '0;
`endif
            end else begin
                r_s1_q    <= w_s1_d;
                r_s2_q    <= w_s2_d;
                r_level_q <= w_level_d;
                r_trig_q  <= w_trig_d;
`ifdef BUTTON_CONDITIONER_DEBOUNCE_EN
                r_cnt_q   <= w_cnt_d;
`endif
            end
        end

        assign w_level[g] = r_level_q;
        assign w_trig[g]  = r_trig_q;
    end

    assign start_level   = w_level[0];
    assign start_trigger = w_trig[0];
    assign user_level    = w_level[1];
    assign user_trigger  = w_trig[1];

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Brief    : Self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4;
//            follows BUTTON_CONDITIONER_DEBOUNCE_EN in the same way as the RTL.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int N = 4;
`ifdef BUTTON_CONDITIONER_DEBOUNCE_EN
    localparam int W = N;
`else
    localparam int W = 1;
`endif
    // Edge (counted from the first edge sampling a steady input) of a level change.
    localparam int L = W + 2;

    logic clk = 1'b0;
    logic rst;
    logic bs;
    logic bu;
    logic st;
    logic ut;
    logic sl;
    logic ul;

    always #5 clk = ~clk;

    button_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_start_raw (bs),
        .btn_user_raw  (bu),
        .start_trigger (st),
        .user_trigger  (ut),
        .start_level   (sl),
        .user_level    (ul)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the value the debouncer sees at edge k is the raw input
    // sampled two edges earlier (zero if reset covered either of those edges).
    // The level flips once the last W of those values all oppose it.
    bit hist [2][0:63];
    int ecount = 64;
    bit m_lvl [2];
    bit m_trg [2];

    task automatic model_edge();
        bit raw [2];
        raw[0] = bs;
        raw[1] = bu;
        ecount++;
        for (int c = 0; c < 2; c++) begin
            bit flip;
            flip = 1'b1;
            hist[c][ecount % 64] = rst ? 1'b0 : raw[c];
            if (rst) hist[c][(ecount - 1) % 64] = 1'b0;
            for (int i = 0; i < W; i++)
                if (hist[c][(ecount - 2 - i) % 64] == m_lvl[c]) flip = 1'b0;
            if (rst) begin
                m_lvl[c] = 1'b0;
                m_trg[c] = 1'b0;
            end else begin
                m_trg[c] = flip && !m_lvl[c];
                if (flip) m_lvl[c] = !m_lvl[c];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bs  = 1'b0;
        bu  = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    function automatic bit pat(input int idx, input bit p [0:15]);
        if (idx < 0 || idx > 15) return 1'b0;
        return p[idx];
    endfunction

    typedef struct {
        bit rst;
        bit bs;
        bit bu;
        bit sl;
        bit st;
        bit ul;
        bit ut;
    } vec_t;

    vec_t tv[$];

    initial begin
        bit gu [0:15];
        bit gs [0:15];
        rst = 1'b1;
        bs  = 1'b0;
        bu  = 1'b0;

        // Table: reset rows, then both buttons pressed on the same edge.
        for (int i = 0; i < 3; i++) tv.push_back('{1, 0, 0, 0, 0, 0, 0});
        for (int e = 1; e <= L + 3; e++)
            tv.push_back('{0, 1, 1, e >= L, e == L, e >= L, e == L});
        foreach (tv[i]) begin
            rst = tv[i].rst;
            bs  = tv[i].bs;
            bu  = tv[i].bu;
            tick();
            chk("tbl_start_level", sl, tv[i].sl);
            chk("tbl_start_trigger", st, tv[i].st);
            chk("tbl_user_level", ul, tv[i].ul);
            chk("tbl_user_trigger", ut, tv[i].ut);
        end

        // Start held: single pulse, no auto-repeat, release, re-press.
        do_reset();
        bs = 1'b1;
        for (int e = 1; e <= L; e++) begin
            tick();
            chk("press_level", sl, e >= L);
            chk("press_trigger", st, e == L);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("hold_no_repeat", st, 1'b0);
        end
        bs = 1'b0;
        for (int e = 1; e <= L; e++) begin
            tick();
            chk("release_level", sl, e < L);
            chk("release_no_trigger", st, 1'b0);
        end
        repeat (10) tick();
        bs = 1'b1;
        for (int e = 1; e <= L + 1; e++) begin
            tick();
            chk("repress_level", sl, e >= L);
            chk("repress_trigger", st, e == L);
        end

        // Glitches: user toggles 1,0,1,0 then 0; start sees a single-cycle pulse.
        do_reset();
        gu = '{default: 1'b0};
        gs = '{default: 1'b0};
        gu[1] = 1'b1;
        gu[3] = 1'b1;
        gs[1] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            bu = gu[e];
            bs = gs[e];
            tick();
            chk("glitch_user_level", ul, (W == 1) ? pat(e - 2, gu) : 1'b0);
            chk("glitch_user_trigger", ut,
                (W == 1) ? (pat(e - 2, gu) && !pat(e - 3, gu)) : 1'b0);
            chk("glitch_start_level", sl, (W == 1) ? (e == 3) : 1'b0);
            chk("glitch_start_trigger", st, (W == 1) ? (e == 3) : 1'b0);
        end

        // Reset mid-press with the button held: fresh press after release.
        do_reset();
        bu = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_user_level", ul, 1'b0);
            chk("rst_user_trigger", ut, 1'b0);
        end
        rst = 1'b0;
        for (int e = 1; e <= L + 2; e++) begin
            tick();
            chk("post_rst_level", ul, e >= L);
            chk("post_rst_trigger", ut, e == L);
        end

        // Random bouncy inputs with occasional reset, against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) bs = ~bs;
            if ($urandom_range(5) == 0) bu = ~bu;
            rst = ($urandom_range(399) == 0);
            tick();
            chk("rand_start_level", sl, m_lvl[0]);
            chk("rand_start_trigger", st, m_trg[0]);
            chk("rand_user_level", ul, m_lvl[1]);
            chk("rand_user_trigger", ut, m_trg[1]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
